// File: rtl/rat_ic_pkg.sv
// Shared types and constants for the RAT multi-channel interrupt controller.
// Holds the FSM state enum, default sizing constants and the channel-to-vector mapping.
package rat_ic_pkg;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} ic_state_t;

   localparam int unsigned IC_NUM_CH_DEF  = 8;
   localparam int unsigned IC_VEC_W_DEF   = 10;
   localparam logic [15:0] IC_VEC_TOP_DEF = 16'h03FF;

   // Channel n vectors downward from the top of the vector table.
   function automatic logic [15:0] ic_vec_of(input logic [15:0] top, input logic [3:0] id);
      return top - {12'd0, id};
   endfunction

endpackage

// File: rtl/rat_ic_prio_enc.sv
// Lowest-index-first priority encoder: flags any active request and reports its index.
module rat_ic_prio_enc #(
   parameter int unsigned N = 8,
   localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req_i,
   output logic           valid_o,
   output logic [IdW-1:0] id_o
);

   always_comb begin
      valid_o = |req_i;
      id_o    = '0;
      // Scan downward so the lowest set index is the last one written.
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req_i[i]) id_o = IdW'(i);
      end
   end

endmodule

// File: rtl/rat_intr_ctrl.sv
// Prioritised NUM_CH-source interrupt controller for the RAT MCU with request/service tracking.
// Define RAT_IC_SYNC_EN to insert a 2-flop synchroniser on every IC_IRQ bit.
module rat_intr_ctrl
   import rat_ic_pkg::*;
#(
   parameter int unsigned       NUM_CH    = IC_NUM_CH_DEF,
   parameter int unsigned       VEC_W     = IC_VEC_W_DEF,
   parameter logic [VEC_W-1:0]  VEC_TOP   = VEC_W'(IC_VEC_TOP_DEF),
   parameter logic [NUM_CH-1:0] EDGE_MASK = {NUM_CH{1'b1}},
   localparam int unsigned      ID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              IC_CLK,
   input  logic              IC_RST_N,
   input  logic [NUM_CH-1:0] IC_IRQ,
   input  logic              IC_I_SET,
   input  logic              IC_I_CLR,
   input  logic              IC_MASK_WE,
   input  logic [NUM_CH-1:0] IC_MASK_DIN,
   input  logic [NUM_CH-1:0] IC_PEND_CLR,
   input  logic              IC_ACK,
   input  logic              IC_RETI,
   output logic              IC_INTR,
   output logic [VEC_W-1:0]  IC_VEC,
   output logic [ID_W-1:0]   IC_ID,
   output logic [NUM_CH-1:0] IC_PEND,
   output logic              IC_GIE
);

   logic [NUM_CH-1:0] irq_s;
   logic [NUM_CH-1:0] irq_prev_q;
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [NUM_CH-1:0] rise, ack_clr, elig;
   logic              gie_q, gie_d;
   logic              win_valid;
   logic [ID_W-1:0]   win_id;
   ic_state_t         state_q, state_d;
   logic              intr_q, intr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [VEC_W-1:0]  vec_q, vec_d;
   logic              ack_go, reti_go;

`ifdef RAT_IC_SYNC_EN
   logic [NUM_CH-1:0] sync1_q, sync2_q;

   always_ff @(posedge IC_CLK or negedge IC_RST_N) begin
      if (!IC_RST_N) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= IC_IRQ;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = IC_IRQ;
`endif

   assign ack_go  = (state_q == REQ) && IC_ACK;
   assign reti_go = (state_q == SERVICE) && IC_RETI;
   assign elig    = pend_q & mask_q;

   rat_ic_prio_enc #(
      .N (NUM_CH)
   ) u_prio_enc (
      .req_i   (elig),
      .valid_o (win_valid),
      .id_o    (win_id)
   );

   always_comb begin
      rise    = irq_s & ~irq_prev_q;
      ack_clr = ack_go ? (NUM_CH'(1) << id_q) : '0;
      // Edge bits: a fresh rise beats any clear in the same cycle. Level bits track the input.
      pend_d  = (EDGE_MASK & ((pend_q & ~(IC_PEND_CLR | ack_clr)) | rise))
              | (~EDGE_MASK & irq_s);
      mask_d  = IC_MASK_WE ? IC_MASK_DIN : mask_q;

      gie_d = gie_q;
      if (IC_I_SET || reti_go) gie_d = 1'b1;
      if (IC_I_CLR || ack_go)  gie_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      intr_d  = intr_q;
      id_d    = id_q;
      vec_d   = vec_q;
      unique case (state_q)
         IDLE: begin
            if (gie_q && win_valid) begin
               state_d = REQ;
               intr_d  = 1'b1;
               id_d    = win_id;
               vec_d   = VEC_W'(ic_vec_of(16'(VEC_TOP), 4'(win_id)));
            end
         end
         REQ: begin
            if (IC_ACK) begin
               state_d = SERVICE;
               intr_d  = 1'b0;
            end else if (IC_I_CLR) begin
               state_d = IDLE;
               intr_d  = 1'b0;
            end
         end
         SERVICE: begin
            if (IC_RETI) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            intr_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge IC_CLK or negedge IC_RST_N) begin
      if (!IC_RST_N) begin
         irq_prev_q <= '0;
         pend_q     <= '0;
         mask_q     <= '0;
         gie_q      <= 1'b0;
         state_q    <= IDLE;
         intr_q     <= 1'b0;
         id_q       <= '0;
         vec_q      <= VEC_TOP;
      end else begin
         irq_prev_q <= irq_s;
         pend_q     <= pend_d;
         mask_q     <= mask_d;
         gie_q      <= gie_d;
         state_q    <= state_d;
         intr_q     <= intr_d;
         id_q       <= id_d;
         vec_q      <= vec_d;
      end
   end

   assign IC_INTR = intr_q;
   assign IC_VEC  = vec_q;
   assign IC_ID   = id_q;
   assign IC_PEND = pend_q;
   assign IC_GIE  = gie_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed self-checking bench for rat_intr_ctrl; channel 1 is level-sensitive, the rest edge.
module tb_rat_intr_ctrl;

`ifdef RAT_IC_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irq, mask_din, pend_clr;
   logic       i_set, i_clr, mask_we, ack, reti;
   logic       intr, gie;
   logic [9:0] vec;
   logic [2:0] id;
   logic [7:0] pend;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rat_intr_ctrl #(
      .NUM_CH    (8),
      .VEC_W     (10),
      .VEC_TOP   (10'h3FF),
      .EDGE_MASK (8'hFD)
   ) dut (
      .IC_CLK      (clk),
      .IC_RST_N    (rst_n),
      .IC_IRQ      (irq),
      .IC_I_SET    (i_set),
      .IC_I_CLR    (i_clr),
      .IC_MASK_WE  (mask_we),
      .IC_MASK_DIN (mask_din),
      .IC_PEND_CLR (pend_clr),
      .IC_ACK      (ack),
      .IC_RETI     (reti),
      .IC_INTR     (intr),
      .IC_VEC      (vec),
      .IC_ID       (id),
      .IC_PEND     (pend),
      .IC_GIE      (gie)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic irq_set(input logic [7:0] v);
      irq = v;
      repeat (SYNC_LAT) step();
   endtask

   task automatic load_mask(input logic [7:0] m);
      mask_we = 1'b1; mask_din = m;
      step();
      mask_we = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rst_intr got %0b want 0", intr); end
      checks++; if (gie !== 1'b0) begin errors++; $display("FAIL rst_gie got %0b want 0", gie); end
      checks++; if (vec !== 10'h3FF) begin errors++; $display("FAIL rst_vec got %h want 3ff", vec); end
      checks++; if (id !== 3'd0) begin errors++; $display("FAIL rst_id got %0d want 0", id); end
      checks++; if (pend !== 8'h00) begin errors++; $display("FAIL rst_pend got %h want 00", pend); end
      rst_n = 1'b1;
      step();
      // Reset mask is zero: a pending edge must not request.
      i_set = 1'b1; step(); i_set = 1'b0;
      checks++; if (gie !== 1'b1) begin errors++; $display("FAIL sei_gie got %0b want 1", gie); end
      irq_set(8'h08); step();
      checks++; if (pend !== 8'h08) begin errors++; $display("FAIL mask0_pend got %h want 08", pend); end
      step(); step();
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL mask0_intr got %0b want 0", intr); end
      pend_clr = 8'h08; i_clr = 1'b1; step(); pend_clr = 8'h00; i_clr = 1'b0;
      checks++; if (pend !== 8'h00) begin errors++; $display("FAIL pclr_pend got %h want 00", pend); end
      checks++; if (gie !== 1'b0) begin errors++; $display("FAIL cli_gie got %0b want 0", gie); end
      irq_set(8'h00); step();
   endtask

   task automatic test_edge_basic();
      mask_we = 1'b1; mask_din = 8'h08; i_set = 1'b1;
      step();
      mask_we = 1'b0; i_set = 1'b0;
      irq_set(8'h08); step();
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL e1_early got %0b want 0", intr); end
      step();
      checks++; if (intr !== 1'b1) begin errors++; $display("FAIL e1_intr got %0b want 1", intr); end
      checks++; if (id !== 3'd3) begin errors++; $display("FAIL e1_id got %0d want 3", id); end
      checks++; if (vec !== 10'h3FC) begin errors++; $display("FAIL e1_vec got %h want 3fc", vec); end
      ack = 1'b1; step(); ack = 1'b0;
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL e1_ack_intr got %0b want 0", intr); end
      checks++; if (gie !== 1'b0) begin errors++; $display("FAIL e1_ack_gie got %0b want 0", gie); end
      checks++; if (pend !== 8'h00) begin errors++; $display("FAIL e1_ack_pend got %h want 00", pend); end
      reti = 1'b1; step(); reti = 1'b0;
      checks++; if (gie !== 1'b1) begin errors++; $display("FAIL e1_reti_gie got %0b want 1", gie); end
      step(); step();
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL e1_rereq got %0b want 0", intr); end
      irq_set(8'h00); step();
   endtask

   task automatic test_priority();
      load_mask(8'hFF);
      irq_set(8'h24); step(); step();
      checks++; if (intr !== 1'b1) begin errors++; $display("FAIL pr_intr got %0b want 1", intr); end
      checks++; if (id !== 3'd2) begin errors++; $display("FAIL pr_id got %0d want 2", id); end
      checks++; if (vec !== 10'h3FD) begin errors++; $display("FAIL pr_vec got %h want 3fd", vec); end
      ack = 1'b1; step(); ack = 1'b0;
      checks++; if (pend !== 8'h20) begin errors++; $display("FAIL pr_pend got %h want 20", pend); end
      reti = 1'b1; step(); reti = 1'b0;
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL pr_idle got %0b want 0", intr); end
      step();
      checks++; if (id !== 3'd5) begin errors++; $display("FAIL pr2_id got %0d want 5", id); end
      checks++; if (vec !== 10'h3FA) begin errors++; $display("FAIL pr2_vec got %h want 3fa", vec); end
      checks++; if (intr !== 1'b1) begin errors++; $display("FAIL pr2_intr got %0b want 1", intr); end
      ack = 1'b1; step(); ack = 1'b0;
      reti = 1'b1; step(); reti = 1'b0;
      irq_set(8'h00); step();
      checks++; if (pend !== 8'h00) begin errors++; $display("FAIL pr_end_pend got %h want 00", pend); end
   endtask

   task automatic test_level();
      irq_set(8'h02); step(); step();
      checks++; if (intr !== 1'b1) begin errors++; $display("FAIL lv_intr got %0b want 1", intr); end
      checks++; if (id !== 3'd1) begin errors++; $display("FAIL lv_id got %0d want 1", id); end
      checks++; if (vec !== 10'h3FE) begin errors++; $display("FAIL lv_vec got %h want 3fe", vec); end
      ack = 1'b1; step(); ack = 1'b0;
      checks++; if (pend !== 8'h02) begin errors++; $display("FAIL lv_ack_pend got %h want 02", pend); end
      reti = 1'b1; step(); reti = 1'b0;
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL lv_idle got %0b want 0", intr); end
      step();
      checks++; if (intr !== 1'b1) begin errors++; $display("FAIL lv_rereq got %0b want 1", intr); end
      checks++; if (id !== 3'd1) begin errors++; $display("FAIL lv_rereq_id got %0d want 1", id); end
      irq_set(8'h00); step();
      checks++; if (pend !== 8'h00) begin errors++; $display("FAIL lv_drop got %h want 00", pend); end
      ack = 1'b1; step(); ack = 1'b0;
      reti = 1'b1; step(); reti = 1'b0;
      step();
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL lv_quiet got %0b want 0", intr); end
   endtask

   task automatic test_pend_clr();
      i_clr = 1'b1; step(); i_clr = 1'b0;
      irq_set(8'h40); step();
      checks++; if (pend !== 8'h40) begin errors++; $display("FAIL pc_set got %h want 40", pend); end
      pend_clr = 8'h40; step(); pend_clr = 8'h00;
      checks++; if (pend !== 8'h00) begin errors++; $display("FAIL pc_clr got %h want 00", pend); end
      irq_set(8'h00); step();
      irq_set(8'h40); pend_clr = 8'h40; step(); pend_clr = 8'h00;
      checks++; if (pend !== 8'h40) begin errors++; $display("FAIL pc_edge_wins got %h want 40", pend); end
      load_mask(8'h00);
      checks++; if (pend !== 8'h40) begin errors++; $display("FAIL pc_mask_keep got %h want 40", pend); end
      irq_set(8'h42); step();
      checks++; if (pend !== 8'h42) begin errors++; $display("FAIL pc_level got %h want 42", pend); end
      pend_clr = 8'h02; step(); pend_clr = 8'h00;
      checks++; if (pend !== 8'h42) begin errors++; $display("FAIL pc_level_clr got %h want 42", pend); end
      i_set = 1'b1; step(); i_set = 1'b0;
      step();
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL pc_masked got %0b want 0", intr); end
      i_set = 1'b1; i_clr = 1'b1; step(); i_set = 1'b0; i_clr = 1'b0;
      checks++; if (gie !== 1'b0) begin errors++; $display("FAIL gie_both got %0b want 0", gie); end
      irq_set(8'h00); pend_clr = 8'h40; step(); pend_clr = 8'h00;
      checks++; if (pend !== 8'h00) begin errors++; $display("FAIL pc_final got %h want 00", pend); end
   endtask

   task automatic test_iclr_req();
      load_mask(8'hFF);
      i_set = 1'b1; step(); i_set = 1'b0;
      irq_set(8'h10); step(); step();
      checks++; if (intr !== 1'b1) begin errors++; $display("FAIL ic_intr got %0b want 1", intr); end
      checks++; if (id !== 3'd4) begin errors++; $display("FAIL ic_id got %0d want 4", id); end
      checks++; if (vec !== 10'h3FB) begin errors++; $display("FAIL ic_vec got %h want 3fb", vec); end
      i_clr = 1'b1; step(); i_clr = 1'b0;
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL ic_drop got %0b want 0", intr); end
      checks++; if (pend !== 8'h10) begin errors++; $display("FAIL ic_pend got %h want 10", pend); end
      step();
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL ic_stay_idle got %0b want 0", intr); end
      i_set = 1'b1; step(); i_set = 1'b0;
      step();
      checks++; if (intr !== 1'b1) begin errors++; $display("FAIL ic_rereq got %0b want 1", intr); end
      checks++; if (id !== 3'd4) begin errors++; $display("FAIL ic_rereq_id got %0d want 4", id); end
      ack = 1'b1; step(); ack = 1'b0;
      // New higher-priority edge plus SEI inside the ISR: no nesting allowed.
      irq_set(8'h14); i_set = 1'b1; step(); i_set = 1'b0;
      checks++; if (gie !== 1'b1) begin errors++; $display("FAIL isr_sei got %0b want 1", gie); end
      step(); step();
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL isr_nest got %0b want 0", intr); end
      reti = 1'b1; step(); reti = 1'b0;
      step();
      checks++; if (intr !== 1'b1) begin errors++; $display("FAIL isr_next got %0b want 1", intr); end
      checks++; if (id !== 3'd2) begin errors++; $display("FAIL isr_next_id got %0d want 2", id); end
   endtask

   task automatic test_reset_mid();
      ack = 1'b1; step(); ack = 1'b0;
      i_set = 1'b1; step(); i_set = 1'b0;
      irq_set(8'h94); step();
      checks++; if (pend !== 8'h80) begin errors++; $display("FAIL rm_pend got %h want 80", pend); end
      rst_n = 1'b0;
      #1;
      checks++; if (gie !== 1'b0) begin errors++; $display("FAIL rm_gie got %0b want 0", gie); end
      checks++; if (pend !== 8'h00) begin errors++; $display("FAIL rm_pend0 got %h want 00", pend); end
      checks++; if (id !== 3'd0) begin errors++; $display("FAIL rm_id got %0d want 0", id); end
      checks++; if (vec !== 10'h3FF) begin errors++; $display("FAIL rm_vec got %h want 3ff", vec); end
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rm_intr got %0b want 0", intr); end
      irq = 8'h00;
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; irq = 8'h00; mask_din = 8'h00; pend_clr = 8'h00;
      i_set = 1'b0; i_clr = 1'b0; mask_we = 1'b0; ack = 1'b0; reti = 1'b0;
      test_reset();
      test_edge_basic();
      test_priority();
      test_level();
      test_pend_clr();
      test_iclr_req();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rat_intr_ctrl.md
Name: rat_intr_ctrl

Overview:
- Multi-channel, prioritised interrupt controller for the RAT MCU.
- Replaces the single INTR input and the single-bit interrupt-enable register with NUM_CH masked, edge- or level-sensitive sources.
- Presents one request, a per-channel vector and a channel ID to the control unit.
- Tracks the service state from acknowledge until RETI.

Parameters:
- NUM_CH, 8, number of interrupt sources (1..16).
- VEC_W, 10, vector width; matches the PC width.
- VEC_TOP, 10'h3FF, vector of channel 0; channel n vectors to VEC_TOP - n.
- EDGE_MASK, {NUM_CH{1'b1}}, per-channel mode: 1 = rising-edge, 0 = level.

Ports:
- IC_CLK  in  1  system clock; all state changes on its rising edge.
- IC_RST_N  in  1  reset, asynchronous and active-low.
- IC_IRQ  in  NUM_CH  raw interrupt sources.
- IC_I_SET  in  1  global enable set (SEI).
- IC_I_CLR  in  1  global enable clear (CLI).
- IC_MASK_WE  in  1  load the mask register.
- IC_MASK_DIN  in  NUM_CH  new mask value; 1 = channel enabled.
- IC_PEND_CLR  in  NUM_CH  write-1-to-clear for edge-pending bits.
- IC_ACK  in  1  control unit is entering the interrupt cycle.
- IC_RETI  in  1  control unit is executing RETIE.
- IC_INTR  out  1  interrupt request to the control unit.
- IC_VEC  out  VEC_W  vector of the winning channel.
- IC_ID  out  $clog2(NUM_CH)  index of the winning channel.
- IC_PEND  out  NUM_CH  raw pending bits, exposed for port reads.
- IC_GIE  out  1  global enable state.

Behaviour:
- Reset values (asynchronous, IC_RST_N low):
  - mask = 0, pending = 0, GIE = 0, state = IDLE.
  - IC_INTR = 0, IC_ID = 0, IC_VEC = VEC_TOP.
- Pending, edge channel:
  - Set on a 0->1 transition of the sampled IRQ.
  - Cleared by IC_PEND_CLR[n] or by IC_ACK while n is the latched winner.
  - A new edge in the same cycle as a clear wins; the bit stays 1.
- Pending, level channel: the bit equals the sampled IRQ level; clears are ignored.
- Eligible set = pending & mask. The winner is the lowest eligible index.
- Mask: IC_MASK_WE loads IC_MASK_DIN next cycle. Masking does not clear pending bits.
- GIE:
  - IC_I_SET sets it; IC_I_CLR clears it.
  - If both are asserted together, the clear wins.
- State machine:
  - IDLE: when GIE=1 and the eligible set is nonzero, latch the winner's ID and vector and go to REQ.
  - REQ:
    - IC_INTR = 1; IC_ID and IC_VEC are held stable even if a higher-priority source arrives.
    - IC_ACK: clear GIE, clear the latched edge-pending bit, go to SERVICE.
    - IC_I_CLR without IC_ACK: go back to IDLE and drop IC_INTR.
  - SERVICE:
    - IC_INTR = 0; no new requests.
    - IC_RETI sets GIE=1 and returns to IDLE.
    - IC_I_SET inside an ISR sets GIE but does not leave SERVICE (no nesting).
  - IC_ACK outside REQ and IC_RETI outside SERVICE are ignored.
- Latency, IRQ edge to IC_INTR: 2 cycles (1 cycle pending register, 1 cycle IDLE->REQ).
- Re-request: a level source still high after RETI re-requests 1 cycle after reaching IDLE.
- Outputs are registered; IC_INTR has no combinational path from inputs.

Optional Feature:
- Macro: RAT_IC_SYNC_EN.
- Defined: each IC_IRQ bit passes through a 2-flop synchroniser (reset 0) before edge/level sampling. Edge-to-INTR latency becomes 4 cycles.
- Undefined: IC_IRQ is sampled directly; the sources must already be synchronous to IC_CLK.

Decomposition:
- Package rat_ic_pkg holds:
  - the state enum ic_state_t {IDLE, REQ, SERVICE};
  - default constants IC_NUM_CH_DEF and IC_VEC_TOP_DEF;
  - the function that computes the vector from the ID.
- Sub-module rat_ic_prio_enc: parametrised lowest-index-first encoder producing a valid flag and an ID.

Test Plan:
- Reset → GIE=0, mask=0x00, INTR=0, VEC=0x3FF.
- Mask=0x08, GIE=1, rising edge on IRQ[3] → INTR=1 two cycles later, ID=3, VEC=0x3FC; ACK → INTR=0, GIE=0, PEND[3]=0; RETI → GIE=1, no re-request.
- Edges on IRQ[5] and IRQ[2] in the same cycle, mask=0xFF → ID=2, VEC=0x3FD served first; after RETI, ID=5, VEC=0x3FA.
- Level channel 1 (EDGE_MASK[1]=0) held high through ACK and RETI → re-request 1 cycle after IDLE, ID=1; drop IRQ[1] → PEND[1]=0 next cycle.
- In REQ with ID=4, assert IC_I_CLR → INTR=0, state IDLE, PEND[4] stays 1; IC_I_SET → re-request with ID=4.
- IC_RST_N low mid-SERVICE → all outputs return to reset values immediately; with RAT_IC_SYNC_EN defined, edge-to-INTR latency = 4 cycles.
